// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Architectural PC register and instruction-fetch controller
//                with a req/ack memory handshake and a decode-side hold.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic              stall_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [ADDR_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic [31:0]       retire_cnt_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_instr;
    logic              r_instr_valid;
    logic [31:0]       r_retire_cnt;

    logic              w_fetching;
    logic              w_retire;

    // Request is decoded straight from state so reset assertion drops it at once.
    assign w_fetching = (r_state == S_FETCH);
    assign w_retire   = (r_state == S_ISSUE) && !stall_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_retire_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        r_instr       <= imem_data_i;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_retire) begin
                        r_pc          <= {pc_next_i[ADDR_W-1:2], 2'b00};
                        r_instr_valid <= 1'b0;
                        r_retire_cnt  <= r_retire_cnt + 32'd1;
                        r_state       <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = w_fetching;
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign pc_plus4_o    = r_pc + ADDR_W'(4);
    assign instr_o       = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign retire_cnt_o  = r_retire_cnt;

endmodule

`default_nettype wire

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the CPU datapath. It sits directly downstream of the 32-bit next-PC 2-to-1 mux, which chooses between PC+4 and the branch target. It registers the mux output as the architectural PC and fetches the instruction at that PC over a request/acknowledge handshake to instruction memory, so memory may take any number of cycles. It holds the fetched instruction for the decode stage until that stage accepts it.

## Interface
- ADDR_W, 32, width of PC, memory address and instruction word
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

- clk_i  input  1  single clock; all state changes on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- pc_next_i  input  ADDR_W  next PC from the next-PC mux
- stall_i  input  1  decode not ready; holds the current instruction
- imem_req_o  output  1  fetch request to instruction memory
- imem_addr_o  output  ADDR_W  fetch address (word aligned)
- imem_ack_i  input  1  memory has data valid on imem_data_i this cycle
- imem_data_i  input  ADDR_W  instruction word from memory
- pc_o  output  ADDR_W  PC of the instruction being fetched or held
- pc_plus4_o  output  ADDR_W  pc_o + 4, fed back to the next-PC mux input 0
- instr_o  output  ADDR_W  fetched instruction
- instr_valid_o  output  1  instr_o is valid for decode
- retire_cnt_o  output  32  count of instructions accepted by decode

## Operation
- State machine has three states: IDLE, FETCH, ISSUE. Use a registered state with two bits.
- Reset (rst_i=0, asynchronous) sets:
  - state=IDLE, pc_o=RESET_PC
  - instr_o=0, instr_valid_o=0, retire_cnt_o=0
  - imem_req_o=0 immediately, without waiting for a clock edge.
- IDLE: the first rising edge after rst_i returns to 1 moves the block to FETCH. There is no other exit from IDLE.
- FETCH:
  - imem_req_o=1 and imem_addr_o=pc_o. Both are decoded from the state, with no added cycle.
  - On a rising edge with imem_ack_i=1: instr_o<=imem_data_i, instr_valid_o<=1, state<=ISSUE.
  - If imem_ack_i=0, stay in FETCH. The address stays stable for as long as the request is high.
- ISSUE:
  - imem_req_o=0 and instr_valid_o=1.
  - On an edge with stall_i=0:
    - pc_o <= {pc_next_i[ADDR_W-1:2], 2'b00}; the low two bits are forced to 0.
    - instr_valid_o<=0
    - retire_cnt_o<=retire_cnt_o+1, wrapping modulo 2^32
    - state<=FETCH
  - On an edge with stall_i=1, all registers hold.
- pc_plus4_o = pc_o + 4, combinational, truncated to ADDR_W. 32'hFFFF_FFFC gives 32'h0000_0000.
- imem_ack_i is ignored in IDLE and in ISSUE. A spurious ack must not change instr_o.
- stall_i is ignored in IDLE and in FETCH.
- pc_next_i is sampled only on the edge where the block leaves ISSUE.

## Timing
- From reset release, imem_req_o first goes high in the cycle after the first rising edge.
- Fetch latency is one cycle plus the memory wait cycles. With ack in the first FETCH cycle, instr_valid_o rises at the next edge.
- Best-case throughput is one instruction every 2 cycles: FETCH, then ISSUE.
- instr_o, pc_o and instr_valid_o change only on clock edges. imem_req_o and imem_addr_o change only on clock edges or on reset assertion.
- Reset asserted in the middle of a fetch abandons the request at once. An ack that arrives after reset while the block is in IDLE is ignored. The fetch restarts from RESET_PC.
- Reset asserted while an instruction is held drops instr_valid_o at once. retire_cnt_o is not incremented.

## Test plan
- Reset and first fetch:
  - Stimulus: hold rst_i=0 for 3 cycles, release, ack on the first request cycle with data 32'h2002_0005.
  - Required: imem_addr_o=0 in the cycle after release; then instr_o=32'h2002_0005, instr_valid_o=1, pc_o=0.
- Wait states:
  - Stimulus: ack delayed by 4 cycles.
  - Required: imem_req_o stays 1 with imem_addr_o constant for 5 cycles; instr_valid_o stays 0 until the edge after the ack.
- Stall and branch:
  - Stimulus: in ISSUE, stall_i=1 for 3 cycles, with pc_next_i=32'h0000_0040 on release.
  - Required: instr_o, pc_o and retire_cnt_o hold during the stall; then pc_o=32'h40, imem_addr_o=32'h40, retire_cnt_o increments by 1.
- Misalignment and wrap:
  - Stimulus: pc_next_i=32'hFFFF_FFFF.
  - Required: pc_o=32'hFFFF_FFFC and pc_plus4_o=32'h0000_0000.
  - Stimulus: preload retire_cnt_o to 32'hFFFF_FFFF, then retire one instruction.
  - Required: retire_cnt_o=0.
- Spurious ack and mid-fetch reset:
  - Stimulus: ack pulses during ISSUE with data 32'hDEAD_BEEF.
  - Required: instr_o is unchanged.
  - Stimulus: rst_i=0 while in FETCH.
  - Required: imem_req_o=0 before the next edge; after release, pc_o=RESET_PC.
